// File: rtl/accu_sched.sv
// accu_sched
// ----------
// Round-robin scheduler that lends one shared 4-sample accumulator to up to
// N_REQ requesters. A granted requester keeps the grant for a whole group of
// GROUP samples. Each sample is forwarded to the accumulator through a
// registered strobe. The scheduler then waits for the accumulator's sum and
// returns it, tagged with the requester index, on a valid/ready result port.
//
// Handshake semantics (all ports of this block): a transfer happens on a
// rising clock edge where valid and ready are both high. A producer holding
// valid keeps its data stable until the transfer. Ready never depends
// combinationally on the valid it qualifies.
//
// Ports
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   req_valid/ready    per-requester sample handshake
//   req_data           per-requester sample; requester i on [8i+7:8i]
//   acc_data_in        sample to the accumulator (registered)
//   acc_valid_in       one-cycle strobe per forwarded sample (registered)
//   acc_data_out       accumulator sum
//   acc_valid_out      accumulator sum strobe; only honoured in WAIT
//   res_data, res_id   returned sum and owning requester index
//   res_valid          result valid, held until res_ready
//   res_ready          result consumer accept
//   err_timeout        one-cycle pulse when the sum never arrives
//   dbg_state          current FSM state (IDLE=0, FEED=1, WAIT=2, RESULT=3)

module accu_sched #(
  parameter int N_REQ   = 4,
  parameter int GROUP   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [8*N_REQ-1:0]   req_data,
  output logic [N_REQ-1:0]     req_ready,
  output logic [7:0]           acc_data_in,
  output logic                 acc_valid_in,
  input  logic [9:0]           acc_data_out,
  input  logic                 acc_valid_out,
  output logic [9:0]           res_data,
  output logic [2:0]           res_id,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic                 err_timeout,
  output logic [1:0]           dbg_state
);

  localparam int IDX_W   = $clog2(N_REQ);
  localparam int CAND_W  = IDX_W + 1;
  localparam int CNT_W   = $clog2(GROUP + 1);
  localparam int TIMER_W = 8;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FEED   = 2'd1,
    S_WAIT   = 2'd2,
    S_RESULT = 2'd3
  } state_e;

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  state_e             state_q,      state_d;
  logic [IDX_W-1:0]   grant_q,      grant_d;
  logic [IDX_W-1:0]   last_grant_q, last_grant_d;
  logic [CNT_W-1:0]   cnt_q,        cnt_d;
  logic [TIMER_W-1:0] timer_q,      timer_d;
  logic [7:0]         acc_data_q,   acc_data_d;
  logic               acc_valid_q,  acc_valid_d;
  logic [9:0]         res_data_q,   res_data_d;
  logic [2:0]         res_id_q,     res_id_d;
  logic               res_valid_q,  res_valid_d;
  logic               err_to_q,     err_to_d;

  // --------------------------------------------------------------------------
  // Round-robin pick: first valid requester after last_grant, wrapping.
  // --------------------------------------------------------------------------
  logic               pick_found;
  logic [IDX_W-1:0]   pick_idx;
  logic [CAND_W-1:0]  cand;

  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = {1'b0, last_grant_q} + CAND_W'(k);
      if (cand >= CAND_W'(N_REQ)) begin
        cand = cand - CAND_W'(N_REQ);
      end
      if (!pick_found && req_valid[cand[IDX_W-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = cand[IDX_W-1:0];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Sample path from the granted requester
  // --------------------------------------------------------------------------
  logic [7:0] grant_sample;
  logic       xfer;

  assign grant_sample = req_data[{grant_q, 3'b000} +: 8];
  assign xfer         = (state_q == S_FEED) && req_valid[grant_q];

  // Ready is decoded only from registered state and grant, so it is free of
  // any combinational path from req_valid.
  always_comb begin
    req_ready = '0;
    if (state_q == S_FEED) begin
      req_ready[grant_q] = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Timer with saturation; timer_inc is the value the timer would take now.
  // --------------------------------------------------------------------------
  logic [TIMER_W-1:0] timer_inc;

  assign timer_inc = (timer_q == {TIMER_W{1'b1}}) ? timer_q : timer_q + 1'b1;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    timer_d      = timer_q;
    acc_data_d   = acc_data_q;
    acc_valid_d  = 1'b0;
    res_data_d   = res_data_q;
    res_id_d     = res_id_q;
    res_valid_d  = res_valid_q;
    err_to_d     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          grant_d = pick_idx;
          cnt_d   = '0;
          state_d = S_FEED;
        end
      end

      S_FEED: begin
        // Grant stays locked through gaps until the whole group is in.
        if (xfer) begin
          acc_data_d  = grant_sample;
          acc_valid_d = 1'b1;
          if (cnt_q < CNT_W'(GROUP)) begin
            cnt_d = cnt_q + 1'b1;
          end
          if (cnt_q == CNT_W'(GROUP - 1)) begin
            state_d = S_WAIT;
            timer_d = '0;
          end
        end
      end

      S_WAIT: begin
        // A returning sum wins over a timeout in the same cycle.
        if (acc_valid_out) begin
          res_data_d  = acc_data_out;
          res_id_d    = 3'(grant_q);
          res_valid_d = 1'b1;
          state_d     = S_RESULT;
        end else if (timer_inc == TIMER_W'(TIMEOUT)) begin
          err_to_d     = 1'b1;
          last_grant_d = grant_q;
          state_d      = S_IDLE;
        end else begin
          timer_d = timer_inc;
        end
      end

      S_RESULT: begin
        if (res_ready) begin
          res_valid_d  = 1'b0;
          last_grant_d = grant_q;
          state_d      = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      grant_q      <= '0;
      last_grant_q <= IDX_W'(N_REQ - 1);
      cnt_q        <= '0;
      timer_q      <= '0;
      acc_data_q   <= '0;
      acc_valid_q  <= 1'b0;
      res_data_q   <= '0;
      res_id_q     <= '0;
      res_valid_q  <= 1'b0;
      err_to_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      timer_q      <= timer_d;
      acc_data_q   <= acc_data_d;
      acc_valid_q  <= acc_valid_d;
      res_data_q   <= res_data_d;
      res_id_q     <= res_id_d;
      res_valid_q  <= res_valid_d;
      err_to_q     <= err_to_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign acc_data_in  = acc_data_q;
  assign acc_valid_in = acc_valid_q;
  assign res_data     = res_data_q;
  assign res_id       = res_id_q;
  assign res_valid    = res_valid_q;
  assign err_timeout  = err_to_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_accu_sched.sv
// Testbench for accu_sched: directed groups per requester, a behavioural
// 4-sample accumulator, and a monitor that checks forwarded samples and
// tagged results against queues filled by the stimulus.

module tb_accu_sched;

  localparam int N  = 4;
  localparam int G  = 4;
  localparam int TO = 15;

  // --------------------------------------------------------------------------
  // Clock / reset / DUT
  // --------------------------------------------------------------------------
  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic [7:0]     acc_data_in;
  logic           acc_valid_in;
  logic [9:0]     acc_data_out;
  logic           acc_valid_out;
  logic [9:0]     res_data;
  logic [2:0]     res_id;
  logic           res_valid;
  logic           res_ready;
  logic           err_timeout;
  logic [1:0]     dbg_state;

  always #5 clk = ~clk;

  accu_sched #(.N_REQ(N), .GROUP(G), .TIMEOUT(TO)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .acc_data_in   (acc_data_in),
    .acc_valid_in  (acc_valid_in),
    .acc_data_out  (acc_data_out),
    .acc_valid_out (acc_valid_out),
    .res_data      (res_data),
    .res_id        (res_id),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .err_timeout   (err_timeout),
    .dbg_state     (dbg_state)
  );

  // --------------------------------------------------------------------------
  // Scoreboard state
  // --------------------------------------------------------------------------
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [12:0] exp_q[$];      // {id[2:0], sum[9:0]}
  logic [7:0]  exp_acc_q[$];  // samples expected on acc_data_in, in order
  int         to_count = 0;
  logic       acc_en = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Requester driver: per-channel sample FIFOs, optional gap between samples
  // --------------------------------------------------------------------------
  logic [7:0] ch_mem [N][32];
  int         ch_head [N];
  int         ch_tail [N];
  int         ch_gap  [N];
  int         gap_cnt [N];
  logic [N-1:0] xfer_s;

  task automatic load_one(input int ch, input logic [7:0] s);
    ch_mem[ch][ch_tail[ch] % 32] = s;
    ch_tail[ch]++;
  endtask

  task automatic load4(input int ch, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] c, input logic [7:0] d);
    load_one(ch, a); load_one(ch, b); load_one(ch, c); load_one(ch, d);
  endtask

  task automatic exp_group(input int id, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] c, input logic [7:0] d,
                           input int sum, input bit has_res);
    exp_acc_q.push_back(a); exp_acc_q.push_back(b);
    exp_acc_q.push_back(c); exp_acc_q.push_back(d);
    if (has_res) exp_q.push_back({3'(id), 10'(sum)});
  endtask

  function automatic bit ch_pending();
    bit p = 1'b0;
    for (int i = 0; i < N; i++) if (ch_head[i] != ch_tail[i]) p = 1'b1;
    return p;
  endfunction

  initial begin
    req_valid = '0;
    req_data  = '0;
    xfer_s    = '0;
    for (int i = 0; i < N; i++) begin
      ch_head[i] = 0; ch_tail[i] = 0; ch_gap[i] = 0; gap_cnt[i] = 0;
    end
    forever begin
      @(negedge clk);
      xfer_s = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (!rst_n) begin
          ch_head[i] = ch_tail[i];
          gap_cnt[i] = 0;
        end else if (xfer_s[i]) begin
          ch_head[i]++;
          gap_cnt[i] = ch_gap[i];
        end else if (gap_cnt[i] > 0) begin
          gap_cnt[i]--;
        end
        req_valid[i] = rst_n && (gap_cnt[i] == 0) && (ch_head[i] != ch_tail[i]);
        req_data[8*i +: 8] = req_valid[i] ? ch_mem[i][ch_head[i] % 32] : 8'h00;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Behavioural accumulator: sums GROUP samples, returns the sum one cycle
  // after the last sample. With acc_en low the sum is silently dropped.
  // --------------------------------------------------------------------------
  int msum  = 0;
  int mcnt  = 0;
  int mhold = 0;
  bit mfire = 1'b0;

  initial begin
    acc_valid_out = 1'b0;
    acc_data_out  = '0;
    forever begin
      @(negedge clk);
      acc_valid_out = 1'b0;
      if (!rst_n) begin
        msum = 0; mcnt = 0; mfire = 1'b0;
      end else begin
        if (mfire) begin
          acc_valid_out = 1'b1;
          acc_data_out  = 10'(mhold);
          mfire         = 1'b0;
        end
        if (acc_valid_in) begin
          msum += int'(acc_data_in);
          mcnt++;
          if (mcnt == G) begin
            if (acc_en) begin
              mhold = msum;
              mfire = 1'b1;
            end
            msum = 0;
            mcnt = 0;
          end
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Monitor: forwarded samples, results, result stability, timeout pulses
  // --------------------------------------------------------------------------
  int          cyc = 0;
  int          gcnt = 0;
  int          wait_cyc = 0;
  bit          prev_hold = 1'b0;
  bit          prev_to = 1'b0;
  logic [12:0] held;

  initial begin
    held = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        gcnt = 0; prev_hold = 1'b0; prev_to = 1'b0;
      end else begin
        check("ready_onehot", 32'($countones(req_ready) <= 1), 1);

        if (acc_valid_in) begin
          if (exp_acc_q.size() == 0) begin
            check("acc_unexpected", 1, 0);
          end else begin
            check("acc_sample", acc_data_in, exp_acc_q.pop_front());
          end
          gcnt++;
          if (gcnt == G) begin
            gcnt     = 0;
            wait_cyc = cyc;
          end
        end

        if (prev_hold) begin
          check("res_held", res_valid, 1);
          if (res_valid) check("res_stable", {res_id, res_data}, held);
        end
        if (res_valid) begin
          if (exp_q.size() == 0) begin
            check("res_unexpected", 1, 0);
          end else if (res_ready) begin
            logic [12:0] e;
            e = exp_q.pop_front();
            check("res_id", res_id, e[12:10]);
            check("res_data", res_data, e[9:0]);
          end
        end
        prev_hold = res_valid && !res_ready;
        held      = {res_id, res_data};

        if (prev_to) check("to_width", err_timeout, 0);
        if (err_timeout) begin
          to_count++;
          check("to_latency", cyc - wait_cyc, TO);
        end
        prev_to = err_timeout;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check_reset_vals();
    check("rst_req_ready", req_ready, 0);
    check("rst_acc_data", acc_data_in, 0);
    check("rst_acc_valid", acc_valid_in, 0);
    check("rst_res_data", res_data, 0);
    check("rst_res_id", res_id, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_err_timeout", err_timeout, 0);
    check("rst_state", dbg_state, 0);
  endtask

  task automatic wait_drain(input int max_cyc);
    int k = 0;
    while ((exp_q.size() != 0 || exp_acc_q.size() != 0 || ch_pending()) && k < max_cyc) begin
      @(negedge clk);
      k++;
    end
    check("drain_in_time", 32'(k < max_cyc), 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_res(input int max_cyc);
    int k = 0;
    @(negedge clk);
    while (!res_valid && k < max_cyc) begin
      @(negedge clk);
      k++;
    end
    check("res_in_time", 32'(k < max_cyc), 1);
  endtask

  // --------------------------------------------------------------------------
  // Directed scenarios
  // --------------------------------------------------------------------------
  initial begin
    rst_n     = 1'b0;
    res_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_vals();
    tick();
    rst_n = 1'b1;

    // Contention: all channels valid, served 0,1,2,3 then ch0 again.
    tick();
    res_ready = 1'b1;
    load4(0, 1, 2, 3, 4);
    load4(0, 255, 0, 17, 1);
    load4(1, 5, 6, 7, 8);
    load4(2, 100, 101, 102, 103);
    load4(3, 200, 201, 202, 203);
    exp_group(0, 1, 2, 3, 4, 10, 1);
    exp_group(1, 5, 6, 7, 8, 26, 1);
    exp_group(2, 100, 101, 102, 103, 406, 1);
    exp_group(3, 200, 201, 202, 203, 806, 1);
    exp_group(0, 255, 0, 17, 1, 273, 1);
    wait_drain(300);

    // Single requester ch2 with cycle-exact FEED timing, result held.
    tick();
    res_ready = 1'b0;
    load4(2, 10, 20, 30, 40);
    exp_group(2, 10, 20, 30, 40, 100, 1);
    tick();
    @(negedge clk);
    check("t0_ready", req_ready, 4'b0000);
    @(negedge clk);
    check("t1_ready", req_ready, 4'b0100);
    check("t1_accv", acc_valid_in, 0);
    repeat (4) begin
      @(negedge clk);
      check("t2_5_accv", acc_valid_in, 1);
    end
    @(negedge clk);
    check("t6_accv", acc_valid_in, 0);
    check("t6_ready", req_ready, 4'b0000);
    wait_res(20);
    repeat (3) @(negedge clk);
    tick();
    res_ready = 1'b1;
    wait_drain(40);

    // Gapped input: ch1 valid every third cycle, grant held.
    tick();
    ch_gap[1] = 2;
    load4(1, 255, 255, 255, 255);
    exp_group(1, 255, 255, 255, 255, 1020, 1);
    begin
      int k = 0;
      while (exp_q.size() != 0 && k < 200) begin
        @(negedge clk);
        check("gap_grant", 32'(req_ready == 4'b0000 || req_ready == 4'b0010), 1);
        k++;
      end
      check("gap_in_time", 32'(k < 200), 1);
    end
    wait_drain(50);
    ch_gap[1] = 0;

    // Result backpressure: ch3 result held 10 cycles while ch0 waits.
    tick();
    res_ready = 1'b0;
    load4(3, 50, 60, 70, 80);
    exp_group(3, 50, 60, 70, 80, 260, 1);
    wait_res(40);
    tick();
    load4(0, 9, 9, 9, 9);
    exp_group(0, 9, 9, 9, 9, 36, 1);
    repeat (10) begin
      @(negedge clk);
      check("bp_valid", res_valid, 1);
      check("bp_data", res_data, 260);
      check("bp_id", res_id, 3);
      check("bp_ready", req_ready, 4'b0000);
    end
    tick();
    res_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_idle_ready", req_ready, 4'b0000);
    @(negedge clk);
    check("bp_next_ready", req_ready, 4'b0001);
    wait_drain(60);

    // Timeout: accumulator silent, then ch2 beats ch1 on the next round.
    tick();
    acc_en = 1'b0;
    load4(1, 3, 3, 3, 3);
    exp_group(1, 3, 3, 3, 3, 0, 0);
    begin
      int k = 0;
      while (to_count == 0 && k < 60) begin
        @(negedge clk);
        k++;
      end
      check("to_seen", 32'(k < 60), 1);
    end
    tick();
    acc_en = 1'b1;
    load4(1, 4, 4, 4, 4);
    load4(2, 6, 6, 6, 6);
    exp_group(2, 6, 6, 6, 6, 24, 1);
    exp_group(1, 4, 4, 4, 4, 16, 1);
    wait_drain(100);
    check("to_count", to_count, 1);

    // Reset mid-FEED: ch3 stalls after 2 samples, reset, ch0 wins afterwards.
    tick();
    load_one(3, 11);
    load_one(3, 12);
    exp_acc_q.push_back(8'd11);
    exp_acc_q.push_back(8'd12);
    begin
      int k = 0;
      while (exp_acc_q.size() != 0 && k < 30) begin
        @(negedge clk);
        k++;
      end
      check("stall_in_time", 32'(k < 30), 1);
    end
    repeat (5) begin
      @(negedge clk);
      check("stall_ready", req_ready, 4'b1000);
      check("stall_state", dbg_state, 1);
    end
    tick();
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_vals();
    tick();
    rst_n = 1'b1;
    tick();
    load4(3, 21, 22, 23, 24);
    load4(0, 1, 1, 1, 1);
    exp_group(0, 1, 1, 1, 1, 4, 1);
    exp_group(3, 21, 22, 23, 24, 90, 1);
    wait_drain(100);

    check("exp_q_empty", exp_q.size(), 0);
    check("exp_acc_q_empty", exp_acc_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

endmodule
